// File: rtl/cdr_os_rx.sv
// Oversampling clock/data recovery receiver: an edge-tracking phase counter
// recovers the bit grid from an asynchronous serial line and strobes out one bit per period.
module cdr_os_rx #(
    parameter int OS_RATIO    = 4,
    parameter int LOCK_EDGES  = 16,
    parameter int UNLOCK_BITS = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        data_i,
    output logic                        data_o,
    output logic                        valid_o,
    output logic                        lock_o,
    output logic [$clog2(OS_RATIO)-1:0] phase_o
);

    localparam int PH_W = $clog2(OS_RATIO);
    localparam int EC_W = $clog2(LOCK_EDGES + 1);
    localparam int IC_W = $clog2(UNLOCK_BITS + 1);

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OS_RATIO - 1);
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(OS_RATIO / 2);
    localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
    localparam logic [EC_W-1:0] EC_MAX  = EC_W'(LOCK_EDGES);
    localparam logic [EC_W-1:0] EC_ONE  = EC_W'(1);
    localparam logic [IC_W-1:0] IC_MAX  = IC_W'(UNLOCK_BITS);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_TRACK,
        ST_LOCKED
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_s1;
    logic            r_s2;
    logic            r_s3;
    logic [PH_W-1:0] r_ph;
    logic [EC_W-1:0] r_edge_cnt;
    logic [EC_W-1:0] w_edge_cnt_nxt;
    logic [EC_W-1:0] w_edge_cnt_inc;
    logic [IC_W-1:0] r_idle_cnt;
    logic            r_data;
    logic            r_valid;
    logic            r_lock;
    logic            w_edge;
    logic            w_in_win;
    logic            w_wrap;
    logic            w_idle_term;
    logic            w_sample;

    function automatic logic [EC_W-1:0] edge_cnt_sat_inc(input logic [EC_W-1:0] v);
        return (v == EC_MAX) ? v : v + EC_ONE;
    endfunction

    function automatic logic [IC_W-1:0] idle_cnt_sat_inc(input logic [IC_W-1:0] v);
        return (v == IC_MAX) ? v : v + IC_W'(1);
    endfunction

    // Edge cycle is phase 0, so a well-timed edge lands at phase OS_RATIO-1, 0 or 1.
    assign w_edge         = r_s2 ^ r_s3;
    assign w_in_win       = (r_ph == PH_LAST) || (r_ph == '0) || (r_ph == PH_ONE);
    assign w_wrap         = (r_ph == PH_LAST);
    assign w_idle_term    = (r_idle_cnt == IC_MAX);
    assign w_sample       = (r_ph == PH_HALF) && !w_edge && (r_state != ST_HUNT);
    assign w_edge_cnt_inc = edge_cnt_sat_inc(r_edge_cnt);

    always_comb begin
        w_state_nxt    = r_state;
        w_edge_cnt_nxt = r_edge_cnt;
        case (r_state)
            ST_HUNT: begin
                if (w_edge) begin
                    w_state_nxt    = ST_TRACK;
                    w_edge_cnt_nxt = EC_ONE;
                end
            end
            ST_TRACK: begin
                if (w_edge) begin
                    if (w_in_win) begin
                        w_edge_cnt_nxt = w_edge_cnt_inc;
                        if (w_edge_cnt_inc == EC_MAX) begin
                            w_state_nxt = ST_LOCKED;
                        end
                    end else begin
                        w_edge_cnt_nxt = EC_ONE;
                    end
                end else if (w_idle_term) begin
                    w_state_nxt    = ST_HUNT;
                    w_edge_cnt_nxt = '0;
                end
            end
            ST_LOCKED: begin
                if (w_edge) begin
                    if (!w_in_win) begin
                        w_state_nxt    = ST_TRACK;
                        w_edge_cnt_nxt = EC_ONE;
                    end
                end else if (w_idle_term) begin
                    w_state_nxt    = ST_HUNT;
                    w_edge_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt    = ST_HUNT;
                w_edge_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_s3       <= 1'b0;
            r_ph       <= '0;
            r_state    <= ST_HUNT;
            r_edge_cnt <= '0;
            r_idle_cnt <= '0;
            r_data     <= 1'b0;
            r_valid    <= 1'b0;
            r_lock     <= 1'b0;
        end else begin
            r_s1       <= data_i;
            r_s2       <= r_s1;
            r_s3       <= r_s2;
            r_state    <= w_state_nxt;
            r_edge_cnt <= w_edge_cnt_nxt;
            r_lock     <= (w_state_nxt == ST_LOCKED);
            r_valid    <= w_sample;
            if (w_sample) begin
                r_data <= r_s2;
            end
            if (w_edge) begin
                r_ph       <= PH_ONE;
                r_idle_cnt <= '0;
            end else begin
                r_ph       <= w_wrap ? '0 : r_ph + PH_ONE;
                r_idle_cnt <= w_wrap ? idle_cnt_sat_inc(r_idle_cnt) : r_idle_cnt;
            end
        end
    end

    assign data_o  = r_data;
    assign valid_o = r_valid;
    assign lock_o  = r_lock;
    assign phase_o = r_ph;

endmodule

// File: tb/tb_cdr_os_rx.sv
// Bench for cdr_os_rx: directed scenarios plus random jittered traffic, every cycle
// compared against a model that derives phase and idle time from the last edge's timestamp.
module tb_cdr_os_rx;

    localparam int OS   = 4;
    localparam int LOCK = 16;
    localparam int UNL  = 64;
    localparam int HALF = OS / 2;
    localparam int M_HUNT   = 0;
    localparam int M_TRACK  = 1;
    localparam int M_LOCKED = 2;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       data_i = 1'b0;
    logic       data_o;
    logic       valid_o;
    logic       lock_o;
    logic [1:0] phase_o;

    int errors = 0;
    int checks = 0;

    // Model state: the line as sampled at each clock, the timestamp of the
    // most recent edge (or reset), and the lock-hunting mode.
    bit   raw [0:8191];
    int   cyc = 4;
    int   rst_cyc = 4;
    int   anchor = 4;
    int   mode = M_HUNT;
    int   ecnt = 0;
    logic ev = 1'b0;
    logic ed = 1'b0;
    logic el = 1'b0;
    int   strobes = 0;
    bit   rec_en = 1'b0;
    bit   rec_q [$];

    always #5 clk_i = ~clk_i;

    cdr_os_rx #(
        .OS_RATIO   (OS),
        .LOCK_EDGES (LOCK),
        .UNLOCK_BITS(UNL)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .data_i (data_i),
        .data_o (data_o),
        .valid_o(valid_o),
        .lock_o (lock_o),
        .phase_o(phase_o)
    );

    function automatic bit line_at(input int k);
        return (k <= rst_cyc) ? 1'b0 : raw[k];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s @cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input bit d, input bit r);
        int c;
        int ph;
        int idle;
        int ph_n;
        bit e_c;
        bit inwin;
        data_i = d;
        rst_i  = r;
        @(posedge clk_i);
        c   = cyc;
        cyc = cyc + 1;
        raw[cyc] = d;
        if (r) begin
            rst_cyc = cyc;
            anchor  = cyc;
            mode    = M_HUNT;
            ecnt    = 0;
            ev      = 1'b0;
            ed      = 1'b0;
            el      = 1'b0;
        end else begin
            e_c  = line_at(c - 1) != line_at(c - 2);
            ph   = (c - anchor) % OS;
            idle = (c - anchor) / OS;
            if (idle > UNL) idle = UNL;
            ev = 1'b0;
            if (!e_c && ph == HALF && mode != M_HUNT) begin
                ev = 1'b1;
                ed = line_at(c - 1);
            end
            if (e_c) begin
                inwin = (ph == OS - 1) || (ph <= 1);
                if (mode == M_HUNT || !inwin) begin
                    mode = M_TRACK;
                    ecnt = 1;
                end else if (mode == M_TRACK) begin
                    ecnt++;
                    if (ecnt >= LOCK) mode = M_LOCKED;
                end
                anchor = c;
            end else if (idle == UNL && mode != M_HUNT) begin
                mode = M_HUNT;
                ecnt = 0;
            end
            el = (mode == M_LOCKED);
        end
        ph_n = (cyc - anchor) % OS;
        #1;
        chk("valid_o", valid_o, ev);
        chk("data_o", data_o, ed);
        chk("lock_o", lock_o, el);
        chk("phase_o", phase_o, ph_n);
        if (valid_o === 1'b1) begin
            strobes++;
            if (rec_en) rec_q.push_back(data_o);
        end
    endtask

    task automatic send_bit(input bit b, input int len);
        repeat (len) step(b, 1'b0);
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] rb;
        bit         b;
        int         len;
        pat = 8'hA5;

        // Reset held with the line toggling
        for (int i = 0; i < 3; i++) begin
            step(i[0], 1'b1);
            chk("rst_valid", valid_o, 0);
            chk("rst_lock", lock_o, 0);
            chk("rst_phase", phase_o, 0);
        end
        repeat (7) step(1'b0, 1'b0);

        // Clean alternating pattern acquires lock
        for (int i = 0; i < 24; i++) send_bit(i[0] ? 1'b0 : 1'b1, OS);
        chk("t2_locked", lock_o, 1);

        // 0xA5 stream with a 5-clock bit every 32 bits
        strobes = 0;
        rec_q.delete();
        rec_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            send_bit(pat[7 - (i % 8)], (i % 32 == 1) ? OS + 1 : OS);
            chk("t3_lock_held", lock_o, 1);
        end
        rec_en = 1'b0;
        chk("t3_strobes", strobes, 64);
        for (int k = 0; k < 7; k++) begin
            rb = '0;
            for (int j = 0; j < 8; j++) rb = {rb[6:0], rec_q[1 + 8 * k + j]};
            chk("t3_byte", rb, 8'hA5);
        end

        // Idle line: strobes for 64 bit periods after the last edge, then lock lost
        strobes = 0;
        repeat (70 * OS) step(1'b1, 1'b0);
        chk("t4_strobes", strobes, 64);
        chk("t4_unlocked", lock_o, 0);
        strobes = 0;
        send_bit(1'b0, OS);
        send_bit(1'b1, OS);
        chk("t4_retrack_strobe", strobes, 1);

        // Relock, then one out-of-window edge
        for (int i = 0; i < 20; i++) send_bit(i[0], OS);
        chk("t5_locked", lock_o, 1);
        send_bit(1'b0, 2);
        send_bit(1'b1, OS);
        chk("t5_lock_drop", lock_o, 0);
        for (int i = 0; i < 14; i++) send_bit(i[0] ? 1'b1 : 1'b0, OS);
        chk("t5_not_yet", lock_o, 0);
        send_bit(1'b0, OS);
        chk("t5_relock", lock_o, 1);

        // Single-cycle reset mid-byte while locked
        for (int i = 0; i < 4; i++) send_bit(pat[7 - i], OS);
        send_bit(pat[3], 2);
        step(1'b0, 1'b1);
        chk("t6_valid", valid_o, 0);
        chk("t6_lock", lock_o, 0);
        chk("t6_data", data_o, 0);
        chk("t6_phase", phase_o, 0);
        for (int i = 0; i < 24; i++) send_bit(i[0] ? 1'b0 : 1'b1, OS);
        chk("t6_relock", lock_o, 1);

        // Random data with occasional jittered or badly timed bits
        for (int i = 0; i < 300; i++) begin
            b   = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 6)) : OS;
            send_bit(b, len);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
